// File: rtl/jtag_tap_target.sv
// JTAG TAP target: 16-state TAP controller with an instruction register and
// bypass, user and boundary-scan data registers.
// Optional feature: define JTAG_TAP_IDCODE_EN to add a 32-bit read-only IDCODE
// register (opcode 00010), which also becomes the instruction loaded in Reset.
// State encoding (jtagState): reset=0, idle=1, drScan=2, irScan=3, captureIr=4,
// shiftIr=5, exit1Ir=6, pauseIr=7, exit2Ir=8, updateIr=9, captureDr=10,
// shiftDr=11, exit1Dr=12, pauseDr=13, exit2Dr=14, updateDr=15.
module jtag_tap_target #(
    parameter int unsigned TEST_VECTOR_WIDTH = 32,
    parameter int unsigned INSTRUCTION_WIDTH = 5
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         jtagTms,
    input  logic                         jtagTdi,
    output logic                         jtagTdo,
    output logic                         jtagTdoEnable,
    output logic [3:0]                   jtagState,
    output logic [INSTRUCTION_WIDTH-1:0] jtagInstruction,
    input  logic [TEST_VECTOR_WIDTH-1:0] userDataIn,
    output logic [TEST_VECTOR_WIDTH-1:0] userDataOut,
    output logic                         userUpdate,
    input  logic [TEST_VECTOR_WIDTH-1:0] boundaryIn,
    output logic [TEST_VECTOR_WIDTH-1:0] boundaryOut
);

    localparam logic [3:0] StReset      = 4'd0;
    localparam logic [3:0] StIdle       = 4'd1;
    localparam logic [3:0] StDrScan     = 4'd2;
    localparam logic [3:0] StIrScan     = 4'd3;
    localparam logic [3:0] StCaptureIr  = 4'd4;
    localparam logic [3:0] StShiftIr    = 4'd5;
    localparam logic [3:0] StExit1Ir    = 4'd6;
    localparam logic [3:0] StPauseIr    = 4'd7;
    localparam logic [3:0] StExit2Ir    = 4'd8;
    localparam logic [3:0] StUpdateIr   = 4'd9;
    localparam logic [3:0] StCaptureDr  = 4'd10;
    localparam logic [3:0] StShiftDr    = 4'd11;
    localparam logic [3:0] StExit1Dr    = 4'd12;
    localparam logic [3:0] StPauseDr    = 4'd13;
    localparam logic [3:0] StExit2Dr    = 4'd14;
    localparam logic [3:0] StUpdateDr   = 4'd15;

    localparam logic [4:0] OpUser     = 5'b00001;
    localparam logic [4:0] OpBoundary = 5'b00110;

`ifdef JTAG_TAP_IDCODE_EN
    localparam logic [4:0]  OpIdcode    = 5'b00010;
    localparam logic [31:0] IdcodeValue = 32'h1000_0001;
    localparam logic [INSTRUCTION_WIDTH-1:0] ResetInstr = INSTRUCTION_WIDTH'(OpIdcode);
`else
    localparam logic [INSTRUCTION_WIDTH-1:0] ResetInstr = '0;
`endif

    logic [3:0]                   state_q, state_d;
    logic [INSTRUCTION_WIDTH-1:0] ir_shift_q, ir_active_q;
    logic                         bypass_q;
    logic [TEST_VECTOR_WIDTH-1:0] user_shift_q, boundary_shift_q;
    logic [TEST_VECTOR_WIDTH-1:0] user_out_q, boundary_out_q;
    logic [4:0]                   opcode;
    logic                         sel_user, sel_boundary;
`ifdef JTAG_TAP_IDCODE_EN
    logic [31:0]                  idcode_shift_q;
    logic                         sel_idcode;
`endif

    // Narrow instructions are zero-extended before decoding.
    assign opcode       = 5'(ir_active_q);
    assign sel_user     = (opcode == OpUser);
    assign sel_boundary = (opcode == OpBoundary);
`ifdef JTAG_TAP_IDCODE_EN
    assign sel_idcode   = (opcode == OpIdcode);
`endif

    // TAP next-state decode keyed by TMS.
    always_comb begin
        state_d = StReset;
        case (state_q)
            StReset:     state_d = jtagTms ? StReset    : StIdle;
            StIdle:      state_d = jtagTms ? StDrScan   : StIdle;
            StDrScan:    state_d = jtagTms ? StIrScan   : StCaptureDr;
            StIrScan:    state_d = jtagTms ? StReset    : StCaptureIr;
            StCaptureIr: state_d = jtagTms ? StExit1Ir  : StShiftIr;
            StShiftIr:   state_d = jtagTms ? StExit1Ir  : StShiftIr;
            StExit1Ir:   state_d = jtagTms ? StUpdateIr : StPauseIr;
            StPauseIr:   state_d = jtagTms ? StExit2Ir  : StPauseIr;
            StExit2Ir:   state_d = jtagTms ? StUpdateIr : StShiftIr;
            StUpdateIr:  state_d = jtagTms ? StDrScan   : StIdle;
            StCaptureDr: state_d = jtagTms ? StExit1Dr  : StShiftDr;
            StShiftDr:   state_d = jtagTms ? StExit1Dr  : StShiftDr;
            StExit1Dr:   state_d = jtagTms ? StUpdateDr : StPauseDr;
            StPauseDr:   state_d = jtagTms ? StExit2Dr  : StPauseDr;
            StExit2Dr:   state_d = jtagTms ? StUpdateDr : StShiftDr;
            StUpdateDr:  state_d = jtagTms ? StDrScan   : StIdle;
            default:     state_d = StReset;
        endcase
    end

    // TAP state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= StReset;
        else        state_q <= state_d;
    end

    // Instruction shift register and active instruction.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ir_shift_q  <= '0;
            ir_active_q <= '0;
        end else begin
            if (state_q == StCaptureIr) begin
                ir_shift_q <= INSTRUCTION_WIDTH'(2'b01);
            end else if (state_q == StShiftIr) begin
                ir_shift_q <= {jtagTdi, ir_shift_q[INSTRUCTION_WIDTH-1:1]};
            end
            // Also reload while sitting in Reset so the first edge after an async
            // reset installs the reset instruction.
            if (state_d == StUpdateIr) begin
                ir_active_q <= ir_shift_q;
            end else if (state_d == StReset || state_q == StReset) begin
                ir_active_q <= ResetInstr;
            end
        end
    end

    // Data register capture and LSB-first shift for the selected register only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bypass_q         <= 1'b0;
            user_shift_q     <= '0;
            boundary_shift_q <= '0;
`ifdef JTAG_TAP_IDCODE_EN
            idcode_shift_q   <= '0;
`endif
        end else if (state_q == StCaptureDr) begin
            if (sel_user)          user_shift_q     <= userDataIn;
            else if (sel_boundary) boundary_shift_q <= boundaryIn;
`ifdef JTAG_TAP_IDCODE_EN
            else if (sel_idcode)   idcode_shift_q   <= IdcodeValue;
`endif
            else                   bypass_q         <= 1'b0;
        end else if (state_q == StShiftDr) begin
            if (sel_user) begin
                user_shift_q <= {jtagTdi, user_shift_q[TEST_VECTOR_WIDTH-1:1]};
            end else if (sel_boundary) begin
                boundary_shift_q <= {jtagTdi, boundary_shift_q[TEST_VECTOR_WIDTH-1:1]};
            end
`ifdef JTAG_TAP_IDCODE_EN
            else if (sel_idcode) begin
                idcode_shift_q <= {jtagTdi, idcode_shift_q[31:1]};
            end
`endif
            else begin
                bypass_q <= jtagTdi;
            end
        end
    end

    // Update latches, written on the edge entering UpdateDr.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            user_out_q     <= '0;
            boundary_out_q <= '0;
        end else if (state_d == StUpdateDr) begin
            if (sel_user)     user_out_q     <= user_shift_q;
            if (sel_boundary) boundary_out_q <= boundary_shift_q;
        end
    end

    // Serial output: bit 0 of the register being shifted, else low.
    always_comb begin
        jtagTdo = 1'b0;
        if (state_q == StShiftIr) begin
            jtagTdo = ir_shift_q[0];
        end else if (state_q == StShiftDr) begin
            if (sel_user)          jtagTdo = user_shift_q[0];
            else if (sel_boundary) jtagTdo = boundary_shift_q[0];
`ifdef JTAG_TAP_IDCODE_EN
            else if (sel_idcode)   jtagTdo = idcode_shift_q[0];
`endif
            else                   jtagTdo = bypass_q;
        end
    end

    assign jtagTdoEnable   = (state_q == StShiftIr) || (state_q == StShiftDr);
    assign jtagState       = state_q;
    assign jtagInstruction = ir_active_q;
    assign userDataOut     = user_out_q;
    assign boundaryOut     = boundary_out_q;
    // Instruction cannot change while in UpdateDr, so this is a clean one-cycle pulse.
    assign userUpdate      = (state_q == StUpdateDr) && sel_user;

endmodule
